// File: rtl/seq_trojan_trigger_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_trojan_trigger_if
// Description : Bus bundle between a benchmark core and the trojan trigger:
//               trigger enable, monitored nets, clean data in and the
//               (possibly corrupted) data out plus the trigger flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_trojan_trigger_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic [WIDTH-1:0] MON;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] DOUT;
    logic             TRIG;

    // Host side: drives the monitored nets and clean data, observes outputs
    modport master (
        output EN, MON, DIN,
        input  DOUT, TRIG
    );

    // Trigger side
    modport slave (
        input  EN, MON, DIN,
        output DOUT, TRIG
    );
endinterface
`default_nettype wire

// File: rtl/seq_trojan_trigger.sv
`default_nettype none
// ============================================================================
// Module      : seq_trojan_trigger
// Description : Sequential trojan benchmark. Counts rare events
//               ((MON & MASK) == (PATTERN & MASK)) while EN is high; after
//               THRESHOLD events it enters FIRE and XORs FLIP_MASK onto the
//               data bus for PAYLOAD_CYCLES cycles (0 = until reset), then
//               goes dormant (ONE_SHOT=1) or re-arms (ONE_SHOT=0).
//               Optional macro TROJAN_CONSEC_EN: a non-event edge with EN=1
//               clears the event count, so events must be consecutive.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_trojan_trigger #(
    parameter int               WIDTH          = 4,
    parameter logic [WIDTH-1:0] MASK           = 4'b1111,
    parameter logic [WIDTH-1:0] PATTERN        = 4'b1010,
    parameter int               THRESHOLD      = 3,
    parameter int               PAYLOAD_CYCLES = 2,
    parameter logic [WIDTH-1:0] FLIP_MASK      = 4'b0001,
    parameter int               ONE_SHOT       = 1
) (
    input  wire logic           CK,
    input  wire logic           RST,
    seq_trojan_trigger_if.slave bus
);

    localparam int EVT_W = $clog2(THRESHOLD + 1);
    localparam int DUR_W = (PAYLOAD_CYCLES == 0) ? 1 : $clog2(PAYLOAD_CYCLES + 1);

    localparam logic [EVT_W-1:0] c_evt_last = EVT_W'(THRESHOLD - 1);
    localparam logic [DUR_W-1:0] c_dur_last =
        DUR_W'((PAYLOAD_CYCLES == 0) ? 0 : PAYLOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;

    logic w_event;
    logic w_fire;

    assign w_event = ((bus.MON & MASK) == (PATTERN & MASK));
    assign w_fire  = (state_q == S_FIRE);

    // Payload is a pure decode of the registered state, so reset removes it
    // immediately and DOUT is exactly DIN whenever TRIG is low.
    assign bus.TRIG = w_fire;
    assign bus.DOUT = bus.DIN ^ (w_fire ? FLIP_MASK : '0);

    // State and counter registers with asynchronous reset
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            evt_cnt_q <= '0;
            dur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            evt_cnt_q <= evt_cnt_d;
            dur_cnt_q <= dur_cnt_d;
        end
    end

    // Next-state logic: event counting in IDLE, payload timing in FIRE
    always_comb begin
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        dur_cnt_d = dur_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.EN) begin
                    if (w_event) begin
                        if (evt_cnt_q == c_evt_last) begin
                            state_d   = S_FIRE;
                            evt_cnt_d = '0;
                        end else begin
                            evt_cnt_d = evt_cnt_q + EVT_W'(1);
                        end
                    end
`ifdef TROJAN_CONSEC_EN
                    else begin
                        // A gap in an enabled run breaks the sequence
                        evt_cnt_d = '0;
                    end
`endif
                end
            end

            S_FIRE: begin
                // PAYLOAD_CYCLES == 0 keeps the payload on until reset
                if (PAYLOAD_CYCLES != 0) begin
                    if (dur_cnt_q == c_dur_last) begin
                        dur_cnt_d = '0;
                        state_d   = (ONE_SHOT != 0) ? S_DONE : S_IDLE;
                    end else begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    end
                end
            end

            S_DONE: begin
                // Dormant until reset
            end

            default: begin
                state_d   = S_IDLE;
                evt_cnt_d = '0;
                dur_cnt_d = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_trojan_trigger.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_trojan_trigger
// Description : Scoreboard bench for seq_trojan_trigger. Three instances:
//               dut0 defaults, dut1 re-arming (ONE_SHOT=0), dut2 persistent
//               payload (PAYLOAD_CYCLES=0). Stimulus pushes hand-computed
//               expectations; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_trojan_trigger;

    localparam logic [3:0] c_ev   = 4'b1010;
    localparam logic [3:0] c_flip = 4'b0001;
`ifdef TROJAN_CONSEC_EN
    localparam logic c_nc = 1'b0;
`else
    localparam logic c_nc = 1'b1;
`endif

    logic       clk;
    logic [2:0] rst_v;
    logic       en;
    logic [3:0] mon;
    logic [3:0] din;

    seq_trojan_trigger_if #(.WIDTH(4)) if0 ();
    seq_trojan_trigger_if #(.WIDTH(4)) if1 ();
    seq_trojan_trigger_if #(.WIDTH(4)) if2 ();

    assign if0.EN = en;  assign if0.MON = mon;  assign if0.DIN = din;
    assign if1.EN = en;  assign if1.MON = mon;  assign if1.DIN = din;
    assign if2.EN = en;  assign if2.MON = mon;  assign if2.DIN = din;

    seq_trojan_trigger u_dut0 (.CK(clk), .RST(rst_v[0]), .bus(if0.slave));
    seq_trojan_trigger #(.ONE_SHOT(0)) u_dut1 (.CK(clk), .RST(rst_v[1]), .bus(if1.slave));
    seq_trojan_trigger #(.PAYLOAD_CYCLES(0)) u_dut2 (.CK(clk), .RST(rst_v[2]), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       trig;
        logic [3:0] dout;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    event chk_ev;

    task automatic push(input int idx, input logic t, input logic [3:0] d, input string tag);
        exp_t e;
        e.idx  = idx;
        e.trig = t;
        e.dout = d ^ (t ? c_flip : 4'b0000);
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // One cycle: drive after the rising edge, expect the outputs seen this cycle
    task automatic step(input int idx, input logic r, input logic e, input logic [3:0] m,
                        input logic [3:0] d, input logic t, input string tag);
        @(posedge clk);
        #1;
        rst_v[idx] = r;
        en         = e;
        mon        = m;
        din        = d;
        push(idx, t, d, tag);
    endtask

    // Raise reset between clock edges and check before any edge arrives
    task automatic async_rst(input int idx, input logic [3:0] d, input string tag);
        @(negedge clk);
        #1;
        rst_v[idx] = 1'b1;
        din        = d;
        #1;
        push(idx, 1'b0, d, tag);
        -> chk_ev;
    endtask

    // Monitor: compare every pending expectation at each sample point
    initial begin
        exp_t       e;
        logic       a_trig;
        logic [3:0] a_dout;
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.idx)
                    0:       begin a_trig = if0.TRIG; a_dout = if0.DOUT; end
                    1:       begin a_trig = if1.TRIG; a_dout = if1.DOUT; end
                    default: begin a_trig = if2.TRIG; a_dout = if2.DOUT; end
                endcase
                n_assert++;
                if (a_trig !== e.trig || a_dout !== e.dout) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got TRIG=%b DOUT=%b, required TRIG=%b DOUT=%b",
                             e.tag, e.idx, a_trig, a_dout, e.trig, e.dout);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_v = 3'b111;
        en    = 1'b0;
        mon   = 4'b0000;
        din   = 4'b0110;
        push(0, 1'b0, 4'b0110, "reset0");
        push(1, 1'b0, 4'b0110, "reset1");
        push(2, 1'b0, 4'b0110, "reset2");

        // ---- dut0: basic fire, 2-cycle window, then DONE
        step(0, 0, 1, c_ev,    4'b0110, 0, "count1");
        step(0, 0, 1, c_ev,    4'b0110, 0, "count2");
        step(0, 0, 1, c_ev,    4'b0110, 0, "count3");
        step(0, 0, 1, 4'b0000, 4'b0110, 1, "fire_c1");
        step(0, 0, 1, 4'b0000, 4'b1001, 1, "fire_c2");
        step(0, 0, 1, 4'b0000, 4'b0110, 0, "done");
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, c_ev, 4'(i * 5), 0, "dormant");
        step(0, 0, 1, 4'b0000, 4'b1111, 0, "dormant_end");

        // ---- dut0: reset re-enables the one-shot trigger
        step(0, 1, 1, c_ev,    4'b0110, 0, "rearm_rst");
        step(0, 0, 1, c_ev,    4'b0110, 0, "rearm_e1");
        step(0, 0, 1, c_ev,    4'b0110, 0, "rearm_e2");
        step(0, 0, 1, c_ev,    4'b0110, 0, "rearm_e3");
        step(0, 0, 1, 4'b0000, 4'b0110, 1, "rearm_fire1");
        step(0, 0, 1, 4'b0000, 4'b0110, 1, "rearm_fire2");
        step(0, 0, 1, 4'b0000, 4'b0110, 0, "rearm_done");

        // ---- dut0: gaps and EN=0 edges in the event run
        step(0, 1, 0, 4'b0000, 4'b0110, 0, "nc_rst");
        step(0, 0, 1, c_ev,    4'b0110, 0, "nc_ev");
        step(0, 0, 1, 4'b0000, 4'b0110, 0, "nc_gap");
        step(0, 0, 1, c_ev,    4'b0110, 0, "nc_ev2");
        step(0, 0, 0, c_ev,    4'b0110, 0, "nc_en0");
        step(0, 0, 1, c_ev,    4'b0110, 0, "nc_ev3");
        step(0, 0, 1, 4'b0000, 4'b0110, c_nc, "nc_fire1");
        step(0, 0, 1, 4'b0000, 4'b0110, c_nc, "nc_fire2");
        step(0, 0, 1, 4'b0000, 4'b0110, 0, "nc_after");

        // ---- dut0: reset during the first FIRE cycle
        step(0, 1, 0, 4'b0000, 4'b0110, 0, "mf_rst");
        step(0, 0, 1, c_ev,    4'b0110, 0, "mf_e1");
        step(0, 0, 1, c_ev,    4'b0110, 0, "mf_e2");
        step(0, 0, 1, c_ev,    4'b0110, 0, "mf_e3");
        step(0, 0, 1, 4'b0000, 4'b0110, 1, "mf_fire");
        async_rst(0, 4'b1111, "mf_async");
        step(0, 0, 1, c_ev,    4'b0110, 0, "mf_p1");
        step(0, 0, 1, c_ev,    4'b0110, 0, "mf_p2");
        step(0, 0, 1, c_ev,    4'b0110, 0, "mf_p3");
        step(0, 0, 1, 4'b0000, 4'b0110, 1, "mf_refire1");
        step(0, 0, 1, 4'b0000, 4'b0110, 1, "mf_refire2");
        step(0, 0, 1, 4'b0000, 4'b0110, 0, "mf_done");

        // ---- dut1: re-arm mode, 6 events (2 ignored during FIRE) -> two windows
        step(1, 0, 1, c_ev,    4'b0110, 0, "ra_e1");
        step(1, 0, 1, c_ev,    4'b0110, 0, "ra_e2");
        step(1, 0, 1, c_ev,    4'b0110, 0, "ra_e3");
        step(1, 0, 1, c_ev,    4'b0110, 1, "ra_w1a");
        step(1, 0, 1, c_ev,    4'b1100, 1, "ra_w1b");
        step(1, 0, 1, c_ev,    4'b0110, 0, "ra_e4");
        step(1, 0, 1, c_ev,    4'b0110, 0, "ra_e5");
        step(1, 0, 1, c_ev,    4'b0110, 0, "ra_e6");
        step(1, 0, 1, 4'b0000, 4'b0110, 1, "ra_w2a");
        step(1, 0, 1, 4'b0000, 4'b0011, 1, "ra_w2b");
        step(1, 0, 1, 4'b0000, 4'b0110, 0, "ra_idle");
        step(1, 0, 1, 4'b0000, 4'b0110, 0, "ra_idle2");

        // ---- dut2: persistent payload until reset
        step(2, 0, 1, c_ev,    4'b0110, 0, "ps_e1");
        step(2, 0, 1, c_ev,    4'b0110, 0, "ps_e2");
        step(2, 0, 1, c_ev,    4'b0110, 0, "ps_e3");
        for (int i = 0; i < 50; i++)
            step(2, 0, i[0], 4'(i), 4'(i * 3), 1, "persist");
        step(2, 1, 1, c_ev,    4'b0110, 0, "ps_rst");
        step(2, 0, 0, 4'b0000, 4'b1000, 0, "ps_after");

        repeat (2) @(negedge clk);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
